// File: rtl/irq_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : irq_controller_pkg
//  Description : Shared constants for the interrupt source controller:
//                line count, register map and bus FSM state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package irq_controller_pkg;

  localparam int c_NUM_IRQ = 7;

  // Register map (CPU A2:A1)
  localparam logic [1:0] c_ADDR_PENDING = 2'd0;
  localparam logic [1:0] c_ADDR_MASK    = 2'd1;
  localparam logic [1:0] c_ADDR_RAW     = 2'd2;
  localparam logic [1:0] c_ADDR_RSVD    = 2'd3;

  // Bus handshake FSM encodings
  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_ACK  = 1'b1;

  // Registers are 7 bits wide on an 8-bit bus; bit 7 always reads 0.
  function automatic logic [7:0] pad_reg(input logic [c_NUM_IRQ-1:0] v);
    return {1'b0, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_sync.sv
`default_nettype none
// ============================================================================
//  Module      : irq_sync
//  Description : 1-bit multi-flop synchroniser with synchronous reset.
//                SYNC_STAGES is expected to be 2 or 3.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] r_chain;

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clk) begin
    if (rst) r_chain <= '0;
    else     r_chain <= {r_chain[SYNC_STAGES-2:0], d};
  end

  assign q = r_chain[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
//  Module      : irq_controller
//  Description : Synchronises seven interrupt sources, latches edge-type
//                lines, masks them and drives active-low IRQ1..IRQ7.
//                PENDING/MASK/RAW registers sit on a DTACK-style bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_controller #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] EDGE_TYPE   = 7'h00,
  parameter logic [6:0] MASK_RESET  = 7'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] src,
  input  logic [6:0] iack_n,
  input  logic       sel_n,
  input  logic       rw,
  input  logic [1:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       dtack_n,
  output logic [6:0] irq_n
);

  import irq_controller_pkg::*;

  logic [c_NUM_IRQ-1:0] w_s;
  logic [c_NUM_IRQ-1:0] r_s_d;
  logic [c_NUM_IRQ-1:0] r_iack_n_d;
  logic [c_NUM_IRQ-1:0] r_pending;
  logic [c_NUM_IRQ-1:0] r_mask;
  logic [c_NUM_IRQ-1:0] w_set;
  logic [c_NUM_IRQ-1:0] w_clr;
  logic [c_NUM_IRQ-1:0] w_pend_next;
  logic [0:0]           r_state;
  logic                 w_bus_start;
  logic                 w_wr;
  logic                 w_wr_pending;
  logic                 w_wr_mask;
  logic [7:0]           w_rd_data;
  logic                 w_unused;

  // Bit 7 of the write data has no register behind it.
  assign w_unused = data_in[7];

  generate
    for (genvar gi = 0; gi < c_NUM_IRQ; gi++) begin : g_sync
      irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (src[gi]),
        .q   (w_s[gi])
      );
    end
  endgenerate

  // A bus cycle starts only from IDLE, so a long sel_n low writes once.
  assign w_bus_start  = (r_state == c_ST_IDLE) & ~sel_n;
  assign w_wr         = w_bus_start & ~rw;
  assign w_wr_pending = w_wr & (addr == c_ADDR_PENDING);
  assign w_wr_mask    = w_wr & (addr == c_ADDR_MASK);

  // Edge lines: set on a rising synchronised edge, clear on IACK falling
  // edge or write-1-to-clear; set wins so a fresh edge is never dropped.
  // Level lines simply follow the synchronised source.
  assign w_set       = w_s & ~r_s_d;
  assign w_clr       = (r_iack_n_d & ~iack_n) | ({c_NUM_IRQ{w_wr_pending}} & data_in[6:0]);
  assign w_pend_next = (EDGE_TYPE & ((r_pending & ~w_clr) | w_set)) | (~EDGE_TYPE & w_s);

  // Register read multiplexer
  always_comb begin
    w_rd_data = 8'h00;
    case (addr)
      c_ADDR_PENDING: w_rd_data = pad_reg(r_pending);
      c_ADDR_MASK:    w_rd_data = pad_reg(r_mask);
      c_ADDR_RAW:     w_rd_data = pad_reg(w_s);
      c_ADDR_RSVD:    w_rd_data = 8'h00;
      default:        w_rd_data = 8'h00;
    endcase
  end

  // Edge-detect history, pending/mask state and registered IRQ outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_d      <= '0;
      r_iack_n_d <= '1;
      r_pending  <= '0;
      r_mask     <= MASK_RESET;
      irq_n      <= 7'h7F;
    end else begin
      r_s_d      <= w_s;
      r_iack_n_d <= iack_n;
      r_pending  <= w_pend_next;
      if (w_wr_mask) r_mask <= data_in[6:0];
      irq_n      <= ~(r_pending & r_mask);
    end
  end

  // Bus handshake: acknowledge on select, hold until select is released
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= c_ST_IDLE;
      dtack_n  <= 1'b1;
      data_out <= 8'h00;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (!sel_n) begin
            r_state <= c_ST_ACK;
            dtack_n <= 1'b0;
            if (rw) data_out <= w_rd_data;
          end
        end
        c_ST_ACK: begin
          if (sel_n) begin
            r_state <= c_ST_IDLE;
            dtack_n <= 1'b1;
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
          dtack_n <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_controller
//  Description : Directed scoreboard bench for irq_controller. Line 6 and
//                line 2 are edge type, line 0 is level type.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] src;
  logic [6:0] iack_n;
  logic       sel_n;
  logic       rw;
  logic [1:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       dtack_n;
  logic [6:0] irq_n;

  irq_controller #(
    .SYNC_STAGES (2),
    .EDGE_TYPE   (7'h44),
    .MASK_RESET  (7'h41)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .src      (src),
    .iack_n   (iack_n),
    .sel_n    (sel_n),
    .rw       (rw),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .dtack_n  (dtack_n),
    .irq_n    (irq_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Expected bus read data, popped when dtack_n falls
  typedef struct {
    logic       is_read;
    logic [7:0] val;
    string      nm;
  } rd_t;
  rd_t rd_q[$];

  // Expected output values at a given clock count. kind 0 irq_n, 1 dtack_n, 2 data_out
  typedef struct {
    int         c;
    int         kind;
    logic [7:0] val;
    string      nm;
  } tm_t;
  tm_t tm_q[$];

  task automatic expect_at(input int c, input int kind, input logic [7:0] val, input string nm);
    tm_q.push_back('{c, kind, val, nm});
  endtask

  // Monitor: compares outputs on the falling edge, away from the active edge
  initial begin : monitor
    logic prev_dtack;
    logic [7:0] got;
    rd_t r;
    prev_dtack = 1'b1;
    forever begin
      @(negedge clk);
      if (prev_dtack && !dtack_n) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL bus_unexpected_ack cyc=%0d", cyc);
        end else begin
          r = rd_q.pop_front();
          if (r.is_read) begin
            checks++;
            if (data_out !== r.val) begin
              errors++;
              $display("FAIL %s got %h want %h", r.nm, data_out, r.val);
            end
          end
        end
      end
      prev_dtack = dtack_n;
      for (int i = tm_q.size() - 1; i >= 0; i--) begin
        if (tm_q[i].c <= cyc) begin
          checks++;
          case (tm_q[i].kind)
            0:       got = {1'b0, irq_n};
            1:       got = {7'b0, dtack_n};
            default: got = data_out;
          endcase
          if (tm_q[i].c < cyc || got !== tm_q[i].val) begin
            errors++;
            $display("FAIL %s cyc=%0d got %h want %h", tm_q[i].nm, tm_q[i].c, got, tm_q[i].val);
          end
          tm_q.delete(i);
        end
      end
    end
  end

  // Wait (bounded) for dtack_n to reach a level; called and returns at a falling edge
  task automatic wait_dtack(input logic lvl, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (dtack_n === lvl) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout got %b want %b", nm, dtack_n, lvl);
    end
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [7:0] exp, input string nm);
    rd_q.push_back('{1'b1, exp, nm});
    sel_n = 1'b0; rw = 1'b1; addr = a;
    wait_dtack(1'b0, nm);
    sel_n = 1'b1;
    wait_dtack(1'b1, nm);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    rd_q.push_back('{1'b0, 8'h00, "wr"});
    sel_n = 1'b0; rw = 1'b0; addr = a; data_in = d;
    wait_dtack(1'b0, "wr");
    sel_n = 1'b1; rw = 1'b1; data_in = 8'h00;
    wait_dtack(1'b1, "wr");
  endtask

  initial begin : stim
    int c;
    rst = 1'b1; src = 7'h7F; iack_n = 7'h7F; sel_n = 1'b1; rw = 1'b1;
    addr = 2'd0; data_in = 8'h00;

    // Reset with all sources high
    expect_at(2, 0, 8'h7F, "rst_irq_n");
    expect_at(2, 1, 8'h01, "rst_dtack_n");
    expect_at(2, 2, 8'h00, "rst_data_out");
    repeat (2) @(negedge clk);
    rst = 1'b0; src = 7'h00;
    repeat (3) @(negedge clk);
    bus_read(2'd1, 8'h41, "rst_mask");

    // Edge line 6: one-cycle pulse latches, IACK clears
    @(negedge clk); c = cyc;
    expect_at(c + 3, 0, 8'h7F, "edge_not_yet");
    expect_at(c + 4, 0, 8'h3F, "edge_irq_low");
    expect_at(c + 8, 0, 8'h3F, "edge_irq_held");
    src[6] = 1'b1;
    @(negedge clk); src[6] = 1'b0;
    repeat (8) @(negedge clk);
    c = cyc;
    expect_at(c + 1, 0, 8'h3F, "iack_before");
    expect_at(c + 2, 0, 8'h7F, "iack_cleared");
    iack_n[6] = 1'b0;
    @(negedge clk); iack_n[6] = 1'b1;
    repeat (3) @(negedge clk);

    // Level line 0: IACK has no effect, dropping src releases it
    @(negedge clk); c = cyc;
    expect_at(c + 3, 0, 8'h7F, "level_not_yet");
    expect_at(c + 4, 0, 8'h7E, "level_low");
    expect_at(c + 7, 0, 8'h7E, "level_iack_ignored");
    expect_at(c + 8, 0, 8'h7E, "level_iack_ignored2");
    src[0] = 1'b1;
    repeat (5) @(negedge clk);
    iack_n[0] = 1'b0;
    @(negedge clk); iack_n[0] = 1'b1;
    repeat (3) @(negedge clk);
    c = cyc;
    expect_at(c + 3, 0, 8'h7E, "level_drop_not_yet");
    expect_at(c + 4, 0, 8'h7F, "level_released");
    src[0] = 1'b0;
    repeat (6) @(negedge clk);

    // Mask: disable while line 6 pending, then enable everything
    @(negedge clk); c = cyc;
    expect_at(c + 4, 0, 8'h3F, "mask_pre_low");
    src[6] = 1'b1;
    @(negedge clk); src[6] = 1'b0;
    repeat (4) @(negedge clk);
    c = cyc;
    expect_at(c + 1, 0, 8'h3F, "mask_wr_latency");
    expect_at(c + 2, 0, 8'h7F, "mask_off_irq");
    bus_write(2'd1, 8'h00);
    bus_read(2'd0, 8'h40, "mask_pending_kept");
    c = cyc;
    expect_at(c + 2, 0, 8'h3F, "mask_on_irq");
    bus_write(2'd1, 8'h7F);
    repeat (2) @(negedge clk);

    // Line 2: new edge lands in the same cycle as the IACK falling edge
    @(negedge clk); c = cyc;
    expect_at(c + 4, 0, 8'h3B, "setclr_irq");
    expect_at(c + 6, 0, 8'h3B, "setclr_irq_held");
    src[2] = 1'b1;
    @(negedge clk); src[2] = 1'b0;
    @(negedge clk); iack_n[2] = 1'b0;
    @(negedge clk); iack_n[2] = 1'b1;
    repeat (4) @(negedge clk);
    bus_read(2'd0, 8'h44, "setclr_pending");

    // Write-1-to-clear with sel_n held low for 5 cycles; a new line 6
    // edge arrives mid-cycle and must survive
    @(negedge clk); c = cyc;
    for (int i = 1; i <= 5; i++) expect_at(c + i, 1, 8'h00, "hold_dtack_low");
    expect_at(c + 6, 1, 8'h01, "hold_dtack_release");
    expect_at(c + 2, 0, 8'h7F, "w1c_irq_cleared");
    expect_at(c + 5, 0, 8'h3F, "w1c_new_edge");
    expect_at(c + 7, 0, 8'h3F, "w1c_once");
    rd_q.push_back('{1'b0, 8'h00, "wr_hold"});
    sel_n = 1'b0; rw = 1'b0; addr = 2'd0; data_in = 8'hFF;
    @(negedge clk); src[6] = 1'b1;
    @(negedge clk); src[6] = 1'b0;
    repeat (3) @(negedge clk);
    sel_n = 1'b1; rw = 1'b1; data_in = 8'h00;
    wait_dtack(1'b1, "wr_hold");
    repeat (2) @(negedge clk);
    bus_read(2'd0, 8'h40, "w1c_pending");

    // RAW and reserved reads
    @(negedge clk); src = 7'h55;
    repeat (3) @(negedge clk);
    bus_read(2'd2, 8'h55, "raw_read");
    bus_read(2'd3, 8'h00, "rsvd_read");
    src = 7'h00;
    repeat (4) @(negedge clk);

    // Reset while the bus cycle is acknowledged
    @(negedge clk); c = cyc;
    rd_q.push_back('{1'b1, 8'h7F, "abort_read"});
    expect_at(c + 1, 1, 8'h00, "abort_dtack_low");
    expect_at(c + 2, 1, 8'h01, "abort_dtack_high");
    expect_at(c + 2, 2, 8'h00, "abort_data_out");
    sel_n = 1'b0; rw = 1'b1; addr = 2'd1;
    @(negedge clk); rst = 1'b1; sel_n = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (5) @(negedge clk);

    if (tm_q.size() != 0 || rd_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL leftover_expect got %0d want 0", tm_q.size() + rd_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
